// File: rtl/jtframe_sort_finder.sv
// Recovers the nibble permutation code (0-23) from (scrambled, expected) sample pairs.
// Each accepted sample is tested against one candidate code per clock, and inconsistent codes are dropped.
module jtframe_sort_finder #(
    parameter int MAXSMP = 16,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    scr,
    input  logic [3:0]    exp,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic          none,
    output logic [4:0]    code,
    output logic [23:0]   mask,
    output logic [CW-1:0] count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] SCAN    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    // Source index for out[3],out[2],out[1],out[0], two bits each, indexed by code
    localparam logic [7:0] PERM_SRC [24] = '{
        8'b11_10_01_00, 8'b11_10_00_01, 8'b11_01_10_00, 8'b11_01_00_10, 8'b11_00_01_10, 8'b11_00_10_01,
        8'b10_11_01_00, 8'b10_11_00_01, 8'b10_01_11_00, 8'b10_01_00_11, 8'b10_00_01_11, 8'b10_00_11_01,
        8'b01_10_11_00, 8'b01_10_00_11, 8'b01_11_10_00, 8'b01_11_00_10, 8'b01_00_11_10, 8'b01_00_10_11,
        8'b00_10_01_11, 8'b00_10_11_01, 8'b00_01_10_11, 8'b00_01_11_10, 8'b00_11_01_10, 8'b00_11_10_01
    };

    logic [1:0]    state_reg;
    logic [23:0]   mask_reg;
    logic [CW-1:0] count_reg;
    logic [4:0]    idx_reg;
    logic [3:0]    scr_reg;
    logic [3:0]    exp_reg;
    logic          done_reg;
    logic          found_reg;
    logic          none_reg;
    logic [4:0]    code_reg;

    logic [23:0]   kill;
    logic [23:0]   mask_next;
    logic [4:0]    pop_next;
    logic [4:0]    first_next;

    // Only the candidate currently addressed by idx_reg can be eliminated
    for (genvar gi = 0; gi < 24; gi++) begin : g_cand
        localparam logic [7:0] SRC = PERM_SRC[gi];
        logic [3:0] permuted;
        assign permuted = {scr_reg[SRC[7:6]], scr_reg[SRC[5:4]], scr_reg[SRC[3:2]], scr_reg[SRC[1:0]]};
        assign kill[gi] = (idx_reg == 5'(gi)) && (permuted != exp_reg);
    end

    assign mask_next = mask_reg & ~kill;

    always_comb begin
        pop_next   = 5'd0;
        first_next = 5'h1F;
        for (int i = 23; i >= 0; i--) begin
            if (mask_next[i]) begin
                pop_next   = pop_next + 5'd1;
                first_next = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            mask_reg  <= 24'hFFFFFF;
            count_reg <= '0;
            idx_reg   <= 5'd0;
            scr_reg   <= 4'd0;
            exp_reg   <= 4'd0;
            done_reg  <= 1'b0;
            found_reg <= 1'b0;
            none_reg  <= 1'b0;
            code_reg  <= 5'h1F;
        end else if (start) begin
            // Restart wins over everything, including a sample offered this cycle
            state_reg <= COLLECT;
            mask_reg  <= 24'hFFFFFF;
            count_reg <= '0;
            idx_reg   <= 5'd0;
            done_reg  <= 1'b0;
            found_reg <= 1'b0;
            none_reg  <= 1'b0;
            code_reg  <= 5'h1F;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (in_valid) begin
                        scr_reg   <= scr;
                        exp_reg   <= exp;
                        count_reg <= count_reg + CW'(1);
                        idx_reg   <= 5'd0;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    mask_reg <= mask_next;
                    if (idx_reg == 5'd23) begin
                        if (pop_next <= 5'd1 || count_reg == CW'(MAXSMP)) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            found_reg <= (pop_next == 5'd1);
                            none_reg  <= (pop_next == 5'd0);
                            code_reg  <= (pop_next == 5'd1) ? first_next : 5'h1F;
                        end else begin
                            state_reg <= COLLECT;
                        end
                    end else begin
                        idx_reg <= idx_reg + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (state_reg == COLLECT);
    assign busy     = (state_reg == COLLECT) || (state_reg == SCAN);
    assign done     = done_reg;
    assign found    = found_reg;
    assign none     = none_reg;
    assign code     = code_reg;
    assign mask     = mask_reg;
    assign count    = count_reg;

endmodule

// File: tb/tb_jtframe_sort_finder.sv
// Bench for jtframe_sort_finder: directed scenarios plus randomized searches against a candidate-set model.
module tb_jtframe_sort_finder;

    localparam int MAXSMP = 4;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    scr = 4'd0;
    logic [3:0]    exp = 4'd0;
    logic          busy, done, found, none;
    logic [4:0]    code;
    logic [23:0]   mask;
    logic [CW-1:0] count;

    jtframe_sort_finder #(.MAXSMP(MAXSMP), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .scr(scr), .exp(exp), .busy(busy), .done(done), .found(found), .none(none),
        .code(code), .mask(mask), .count(count)
    );

    always #5 clk = ~clk;

    // Table written as decimal digits: thousands digit is the source of out[3]
    int tbl [24] = '{3210, 3201, 3120, 3102, 3012, 3021,
                     2310, 2301, 2130, 2103, 2013, 2031,
                     1230, 1203, 1320, 1302, 1032, 1023,
                     213,  231,  123,  132,  312,  321};

    int n_checks = 0;
    int n_err    = 0;

    logic [23:0] m_mask;
    int          m_count;
    bit          m_done;

    function automatic logic [3:0] ref_perm(input int n, input logic [3:0] s);
        logic [3:0] r;
        int d, p;
        d = tbl[n];
        p = 1;
        for (int k = 0; k < 4; k++) begin
            r[k] = s[(d / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int ref_pop(input logic [23:0] m);
        int c = 0;
        for (int i = 0; i < 24; i++) if (m[i]) c++;
        return c;
    endfunction

    function automatic int ref_code(input logic [23:0] m);
        if (ref_pop(m) != 1) return 31;
        for (int i = 0; i < 24; i++) if (m[i]) return i;
        return 31;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_mask  = 24'hFFFFFF;
        m_count = 0;
        m_done  = 1'b0;
        chk("start_mask", 32'(mask), 32'hFFFFFF);
        chk("start_count", 32'(count), 32'd0);
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_code", 32'(code), 32'h1F);
    endtask

    task automatic send(input logic [3:0] s, input logic [3:0] e);
        int t;
        int bad;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        scr = s;
        exp = e;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        m_count++;
        for (int n = 0; n < 24; n++)
            if (ref_perm(n, s) != e) m_mask[n] = 1'b0;
        m_done = (ref_pop(m_mask) <= 1) || (m_count == MAXSMP);
        bad = 0;
        for (int i = 0; i < 23; i++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("scan_ready_low", 32'(bad), 32'd0);
        @(negedge clk);
        chk("mask", 32'(mask), 32'(m_mask));
        chk("count", 32'(count), 32'(m_count));
        chk("done", 32'(done), 32'(m_done));
        if (m_done) begin
            chk("found", 32'(found), 32'(ref_pop(m_mask) == 1));
            chk("none", 32'(none), 32'(ref_pop(m_mask) == 0));
            chk("code", 32'(code), 32'(ref_code(m_mask)));
        end
        $display("sample scr=%b exp=%b mask=%06h count=%0d done=%0d code=%0d",
                 s, e, mask, count, done, code);
    endtask

    initial begin
        int tgt;
        logic [3:0] s, e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mask", 32'(mask), 32'hFFFFFF);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_code", 32'(code), 32'h1F);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Unique identification of code 1
        do_start();
        send(4'b0001, 4'b0010);
        chk("t1_mask1", 32'(mask), 32'h00A28A);
        send(4'b0010, 4'b0001);
        chk("t1_mask2", 32'(mask), 32'h000082);
        send(4'b0100, 4'b0100);
        chk("t1_found", 32'(found), 32'd1);
        chk("t1_code", 32'(code), 32'd1);
        chk("t1_count", 32'(count), 32'd3);

        // Contradiction
        do_start();
        send(4'b0001, 4'b0000);
        chk("t2_none", 32'(none), 32'd1);
        chk("t2_found", 32'(found), 32'd0);
        chk("t2_mask", 32'(mask), 32'd0);

        // Ambiguous limit
        do_start();
        for (int i = 0; i < 4; i++) send(4'b0000, 4'b0000);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_found", 32'(found), 32'd0);
        chk("t3_none", 32'(none), 32'd0);
        chk("t3_code", 32'(code), 32'h1F);
        chk("t3_mask", 32'(mask), 32'hFFFFFF);
        in_valid = 1'b1;
        chk("t3_ready5", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t3_count5", 32'(count), 32'd4);

        // start beats a same-cycle sample
        do_start();
        start = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        chk("prio_count", 32'(count), 32'd0);
        chk("prio_ready", 32'(in_ready), 32'd1);

        // Restart mid-scan at idx 10
        do_start();
        scr = 4'b0001;
        exp = 4'b0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rs_mask", 32'(mask), 32'hFFFFFF);
        chk("rs_count", 32'(count), 32'd0);
        chk("rs_ready", 32'(in_ready), 32'd1);
        m_mask = 24'hFFFFFF;
        m_count = 0;
        send(4'b0001, 4'b0010);
        send(4'b0010, 4'b0001);
        send(4'b0100, 4'b0100);
        chk("rs_code", 32'(code), 32'd1);
        chk("rs_count3", 32'(count), 32'd3);

        // Asynchronous reset mid-scan
        do_start();
        scr = 4'b0001;
        exp = 4'b0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_mask", 32'(mask), 32'hFFFFFF);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_ready_after", 32'(in_ready), 32'd0);
        chk("ar_done_after", 32'(done), 32'd0);

        // Exhaustive over all codes
        for (int n = 0; n < 24; n++) begin
            do_start();
            send(4'b0001, ref_perm(n, 4'b0001));
            send(4'b0010, ref_perm(n, 4'b0010));
            send(4'b0100, ref_perm(n, 4'b0100));
            chk("ex_found", 32'(found), 32'd1);
            chk("ex_code", 32'(code), 32'(n));
            chk("ex_count", 32'(count), 32'd3);
        end

        // Randomized searches, occasionally with corrupted expected nibbles
        for (int r = 0; r < 20; r++) begin
            do_start();
            tgt = $urandom_range(23);
            for (int k = 0; k < MAXSMP && !m_done; k++) begin
                s = 4'($urandom_range(15));
                e = ($urandom_range(4) == 0) ? 4'($urandom_range(15)) : ref_perm(tgt, s);
                send(s, e);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
